// File: rtl/ball_motion.sv
// Per-frame motion engine for the bouncing-ball sprite.
// Advances X, height, velocity, direction and glow once per frame strobe.
module ball_motion #(
    parameter int unsigned RANGE_X     = 608,
    parameter int unsigned SPEED_X     = 9,
    parameter int unsigned INIT_VEL_Y  = 21,
    parameter int unsigned BOUNCE_BASE = 17,
    parameter int unsigned GLOW_RESET  = 10,
    parameter int unsigned GLOW_PULSE  = 200,
    parameter int unsigned GLOW_STEP   = 10,
    parameter int unsigned GLOW_MIN    = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        pause,
    output logic [9:0]  o_px,
    output logic [9:0]  o_py,
    output logic        o_dx,
    output logic [10:0] o_glow,
    output logic [3:0]  o_t,
    output logic        o_bounce,
    output logic        o_edge
);

    localparam logic [9:0]  RX    = 10'(RANGE_X);
    localparam logic [12:0] XMAX  = 13'(RANGE_X * 4);
    localparam logic [12:0] SPDX  = 13'(SPEED_X);
    localparam logic [7:0]  VINIT = 8'(INIT_VEL_Y);
    localparam logic [7:0]  VBASE = 8'(BOUNCE_BASE);
    localparam logic [10:0] GRST  = 11'(GLOW_RESET);
    localparam logic [10:0] GPUL  = 11'(GLOW_PULSE);
    localparam logic [10:0] GSTP  = 11'(GLOW_STEP);
    localparam logic [10:0] GMIN  = 11'(GLOW_MIN);

    logic [11:0] pxm_q, pxm_d;
    logic [11:0] pym_q, pym_d;
    logic [7:0]  vel_q, vel_d;
    logic        dx_q, dx_d;
    logic [10:0] glow_q, glow_d;
    logic [3:0]  t_q, t_d;
    logic        bounce_q, bounce_d;
    logic        edge_q, edge_d;

    logic        upd;
    logic [9:0]  px;
    logic        hit_r;
    logic        hit_l;
    logic        dnext;
    logic [8:0]  vmag;
    logic        gb;
    logic [12:0] x_sum;
    logic [12:0] x_right;
    logic [11:0] x_left;

    assign upd   = frame_tick & ~pause;
    assign px    = pxm_q[11:2];
    assign hit_r = (px >= RX);
    assign hit_l = (px == 10'd0);
    assign dnext = hit_r ? 1'b0 : (hit_l ? 1'b1 : dx_q);

    // Magnitude of a negative velocity; 9 bits so -128 stays representable.
    assign vmag = 9'd0 - {vel_q[7], vel_q};
    assign gb   = vel_q[7] & ({3'd0, vmag} >= pym_q);

    assign x_sum   = {1'b0, pxm_q} + SPDX;
    assign x_right = (x_sum > XMAX) ? XMAX : x_sum;
    assign x_left  = ({1'b0, pxm_q} < SPDX) ? 12'd0
                                            : 12'(x_sum - SPDX - SPDX);

    always_comb begin
        pxm_d    = pxm_q;
        pym_d    = pym_q;
        vel_d    = vel_q;
        dx_d     = dx_q;
        glow_d   = glow_q;
        t_d      = t_q;
        bounce_d = 1'b0;
        edge_d   = 1'b0;
        if (upd) begin
            dx_d  = dnext;
            pxm_d = dnext ? x_right[11:0] : x_left;
            if (gb) begin
                pym_d = 12'd0;
                vel_d = VBASE + {5'd0, px[2:0]};
            end else begin
                pym_d = pym_q + {{4{vel_q[7]}}, vel_q};
                vel_d = vel_q - 8'd1;
            end
            if (gb | hit_r | hit_l) begin
                glow_d = GPUL;
            end else if (glow_q > GMIN) begin
                glow_d = glow_q - GSTP;
            end
            t_d      = t_q + 4'd1;
            bounce_d = gb;
            edge_d   = hit_r | hit_l;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pxm_q    <= 12'd0;
            pym_q    <= 12'd0;
            vel_q    <= VINIT;
            dx_q     <= 1'b1;
            glow_q   <= GRST;
            t_q      <= 4'd0;
            bounce_q <= 1'b0;
            edge_q   <= 1'b0;
        end else begin
            pxm_q    <= pxm_d;
            pym_q    <= pym_d;
            vel_q    <= vel_d;
            dx_q     <= dx_d;
            glow_q   <= glow_d;
            t_q      <= t_d;
            bounce_q <= bounce_d;
            edge_q   <= edge_d;
        end
    end

    assign o_px     = px;
    assign o_py     = pym_q[9:0];
    assign o_dx     = dx_q;
    assign o_glow   = glow_q;
    assign o_t      = t_q;
    assign o_bounce = bounce_q;
    assign o_edge   = edge_q;

endmodule

// File: tb/tb_ball_motion.sv
// Directed and randomized check of ball_motion against an integer model.
module tb_ball_motion;

    logic        clk;
    logic        rst_n;
    logic        frame_tick;
    logic        pause;
    logic [9:0]  o_px;
    logic [9:0]  o_py;
    logic        o_dx;
    logic [10:0] o_glow;
    logic [3:0]  o_t;
    logic        o_bounce;
    logic        o_edge;

    int tests;
    int failed;

    // Reference state: quarter-pixel x, height y, velocity v, etc.
    int m_x, m_y, m_v, m_d, m_g, m_t, m_b, m_e;
    int ticks;

    ball_motion dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .pause      (pause),
        .o_px       (o_px),
        .o_py       (o_py),
        .o_dx       (o_dx),
        .o_glow     (o_glow),
        .o_t        (o_t),
        .o_bounce   (o_bounce),
        .o_edge     (o_edge)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0; m_v = 21; m_d = 1;
        m_g = 10; m_t = 0; m_b = 0; m_e = 0;
        ticks = 0;
    endtask

    task automatic model_step();
        int px, nd;
        bit hr, hl, gb;
        px = m_x / 4;
        hr = (px >= 608);
        hl = (px == 0);
        nd = hr ? 0 : (hl ? 1 : m_d);
        m_d = nd;
        if (nd == 1) m_x = (m_x + 9 > 2432) ? 2432 : m_x + 9;
        else         m_x = (m_x < 9) ? 0 : m_x - 9;
        gb = (m_v < 0) && (m_y <= -m_v);
        if (gb) begin
            m_y = 0;
            m_v = 17 + (px % 8);
        end else begin
            m_y = m_y + m_v;
            m_v = m_v - 1;
        end
        if (gb || hr || hl) m_g = 200;
        else if (m_g > 15)  m_g = m_g - 10;
        m_t = (m_t + 1) % 16;
        m_b = gb;
        m_e = hr || hl;
        ticks++;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".px"},     int'(o_px),     m_x / 4);
        check({tag, ".py"},     int'(o_py),     m_y % 1024);
        check({tag, ".dx"},     int'(o_dx),     m_d);
        check({tag, ".glow"},   int'(o_glow),   m_g);
        check({tag, ".t"},      int'(o_t),      m_t);
        check({tag, ".bounce"}, int'(o_bounce), m_b);
        check({tag, ".edge"},   int'(o_edge),   m_e);
    endtask

    // One-cycle frame_tick; outputs compared on the following negedge.
    task automatic tick(input bit p);
        @(negedge clk);
        check("idle.bounce", int'(o_bounce), 0);
        check("idle.edge",   int'(o_edge),   0);
        pause = p;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        pause = 1'b0;
        if (!p) begin
            model_step();
        end else begin
            m_b = 0;
            m_e = 0;
        end
        check_all("tick");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
        m_b = 0;
        m_e = 0;
    endtask

    initial begin
        tests = 0;
        failed = 0;
        rst_n = 1'b0;
        frame_tick = 1'b0;
        pause = 1'b0;
        model_reset();

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("reset");
        idle(100);
        check_all("hold");

        // First tick leaves the left edge.
        tick(1'b0);
        check("t1.px",   int'(o_px),   2);
        check("t1.py",   int'(o_py),   21);
        check("t1.glow", int'(o_glow), 200);
        check("t1.edge", int'(o_edge), 1);
        check("t1.t",    int'(o_t),    1);

        while (ticks < 43) tick(1'b0);
        check("t43.py",     int'(o_py),     0);
        check("t43.bounce", int'(o_bounce), 1);
        check("t43.glow",   int'(o_glow),   200);
        tick(1'b0);
        check("t44.py", int'(o_py), 23);

        while (ticks < 271) tick(1'b0);
        check("t271.px", int'(o_px), 608);
        check("t271.dx", int'(o_dx), 1);
        tick(1'b0);
        check("t272.px",   int'(o_px),   605);
        check("t272.dx",   int'(o_dx),   0);
        check("t272.edge", int'(o_edge), 1);
        check("t272.glow", int'(o_glow), 200);

        // Paused ticks are dropped entirely.
        for (int i = 0; i < 5; i++) tick(1'b1);
        tick(1'b0);

        for (int i = 0; i < 700; i++) begin
            idle($urandom_range(0, 3));
            tick($urandom_range(0, 7) == 0);
        end

        // Reset coincident with a frame tick discards the update.
        @(negedge clk);
        frame_tick = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        frame_tick = 1'b0;
        rst_n = 1'b1;
        model_reset();
        check_all("rst_tick");
        tick(1'b0);
        check("post_rst.px", int'(o_px), 2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
